mul_accum_stage: RTL and testbench

//  Downstream consumer of the n-bit integer multiplier: takes its WIDTH-bit truncated product.

---
 rtl/mul_accum_stage.sv | 97 +++++++++
 tb/tb_mul_accum_stage.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_accum_stage.sv
// Multiply-accumulate reduction stage: sums LEN unsigned products into one ACC_WIDTH result.
// Optional build macro MUL_ACCUM_SAT_EN selects saturating accumulation instead of wrap-around.
module mul_accum_stage #(
    parameter int WIDTH     = 8,
    parameter int LEN       = 4,
    parameter int ACC_WIDTH = WIDTH + $clog2(LEN)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     prod_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] acc_out,
    output logic                 ovf,
    output logic                 dbg_state
);

    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH:0]   sum;
    logic [ACC_WIDTH-1:0] next_acc;
    logic                 carry;
    logic                 accept;
    logic                 done;

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // valid never waits on ready, and the held result stays stable until it is taken.
    assign in_ready  = (state == ACCUM) & ~clr;
    assign accept    = in_valid & in_ready;
    assign done      = out_valid & out_ready;
    assign dbg_state = (state == HOLD);

    assign sum   = {1'b0, acc} + (ACC_WIDTH + 1)'(prod_in);
    assign carry = sum[ACC_WIDTH];

`ifdef MUL_ACCUM_SAT_EN
    assign next_acc = carry ? '1 : sum[ACC_WIDTH-1:0];
`else
    assign next_acc = sum[ACC_WIDTH-1:0];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ACCUM;
            cnt       <= '0;
            acc       <= '0;
            acc_out   <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
        end else if (clr) begin
            state     <= ACCUM;
            cnt       <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        // First product of a result restarts the sticky overflow flag.
                        ovf <= (cnt == '0) ? carry : (ovf | carry);
                        if (cnt == CNT_LAST) begin
                            acc_out   <= next_acc;
                            acc       <= '0;
                            cnt       <= '0;
                            out_valid <= 1'b1;
                            state     <= HOLD;
                        end else begin
                            acc <= next_acc;
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (done) begin
                        out_valid <= 1'b0;
                        state     <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_accum_stage.sv
// Bench for mul_accum_stage: directed scenarios plus random traffic against a sum-of-products model.
// Main instance uses WIDTH=8, LEN=4, ACC_WIDTH=8; a second instance covers LEN=1.
module tb_mul_accum_stage;

    localparam int W    = 8;
    localparam int L    = 4;
    localparam int AW   = 8;
    localparam int AMAX = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  prod_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [AW-1:0] acc_out;
    logic          ovf;
    logic          dbg_state;

    logic          l1_clr = 1'b0;
    logic          l1_in_valid = 1'b0;
    logic          l1_in_ready;
    logic [W-1:0]  l1_prod_in = '0;
    logic          l1_out_valid;
    logic          l1_out_ready = 1'b1;
    logic [W-1:0]  l1_acc_out;
    logic          l1_ovf;
    logic          l1_dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    mul_accum_stage #(.WIDTH(W), .LEN(L), .ACC_WIDTH(AW)) u_dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .prod_in(prod_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .acc_out(acc_out), .ovf(ovf), .dbg_state(dbg_state)
    );

    mul_accum_stage #(.WIDTH(W), .LEN(1)) u_len1 (
        .clk(clk), .rst_n(rst_n), .clr(l1_clr),
        .in_valid(l1_in_valid), .in_ready(l1_in_ready), .prod_in(l1_prod_in),
        .out_valid(l1_out_valid), .out_ready(l1_out_ready),
        .acc_out(l1_acc_out), .ovf(l1_ovf), .dbg_state(l1_dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: results awaiting hand-off, plus products of the result being built.
    logic [AW-1:0] exp_q[$];
    logic          ovf_q[$];
    int            part_q[$];
    logic [AW-1:0] exp_acc  = '0;
    logic          ovf_idle = 1'b0;
    bit            armed    = 1'b0;

    function automatic int part_sum();
        int s = 0;
        foreach (part_q[i]) s += part_q[i];
        return s;
    endfunction

    always @(negedge clk) begin
        bit   pend;
        logic exp_ovf;
        int   s;
        pend = (exp_q.size() != 0);
        if (armed) begin
            if (pend)                    exp_ovf = ovf_q[0];
            else if (part_q.size() != 0) exp_ovf = (part_sum() > AMAX);
            else                         exp_ovf = ovf_idle;
            check("out_valid", out_valid, pend);
            check("in_ready", in_ready, !pend && !clr);
            check("acc_out", acc_out, exp_acc);
            check("ovf", ovf, exp_ovf);
        end
        if (!rst_n) begin
            armed = 1'b1;
            exp_q.delete(); ovf_q.delete(); part_q.delete();
            exp_acc  = '0;
            ovf_idle = 1'b0;
        end else if (armed) begin
            if (clr) begin
                exp_q.delete(); ovf_q.delete(); part_q.delete();
                ovf_idle = 1'b0;
            end else if (pend) begin
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    void'(ovf_q.pop_front());
                end
            end else if (in_valid) begin
                part_q.push_back(int'(prod_in));
                if (part_q.size() == L) begin
                    s = part_sum();
`ifdef MUL_ACCUM_SAT_EN
                    exp_acc = (s > AMAX) ? AW'(AMAX) : AW'(s);
`else
                    exp_acc = AW'(s % (AMAX + 1));
`endif
                    ovf_idle = (s > AMAX);
                    exp_q.push_back(exp_acc);
                    ovf_q.push_back(ovf_idle);
                    part_q.delete();
                end
            end
        end
    end

    // Drivers: inputs change 1 time unit after the rising edge.
    task automatic send(input logic [W-1:0] p);
        int n = 0;
        in_valid = 1'b1;
        prod_in  = p;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        prod_in  = W'($urandom);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        logic [W-1:0] p;
`ifdef MUL_ACCUM_SAT_EN
        logic [AW-1:0] exp_big = 8'd255;
`else
        logic [AW-1:0] exp_big = 8'd252;
`endif
        repeat (2) tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_acc_out", acc_out, 0);
        check("rst_in_ready", in_ready, 1);
        tick();

        // Back-to-back sum
        send(3); send(5); send(7); send(9);
        @(negedge clk);
        check("t1_valid", out_valid, 1);
        check("t1_acc", acc_out, 24);
        check("t1_ovf", ovf, 0);
        tick();

        // Backpressure
        out_ready = 1'b0;
        send(3); send(5); send(7); send(9);
        repeat (5) begin
            @(negedge clk);
            check("t2_in_ready", in_ready, 0);
            check("t2_acc", acc_out, 24);
        end
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        check("t2_released", out_valid, 0);
        check("t2_in_ready_after", in_ready, 1);
        tick();

        // Gapped input
        send(10); tick(); send(20); tick(); send(30); tick(); send(40);
        @(negedge clk);
        check("t3_acc", acc_out, 100);
        tick();

        // Overflow
        repeat (4) send(255);
        @(negedge clk);
        check("t4_acc", acc_out, exp_big);
        check("t4_ovf", ovf, 1);
        tick();

        // Abort mid-sum, then abort a held result
        out_ready = 1'b0;
        send(1); send(2);
        clr = 1'b1; tick(); clr = 1'b0;
        repeat (4) send(4);
        @(negedge clk);
        check("t5_acc", acc_out, 16);
        check("t5_ovf", ovf, 0);
        tick();
        clr = 1'b1; tick(); clr = 1'b0;
        @(negedge clk);
        check("t5_clr_hold", out_valid, 0);
        tick();

        // Reset while holding
        repeat (4) send(1);
        @(negedge clk);
        check("t6_held", out_valid, 1);
        tick();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        @(negedge clk);
        check("t6_valid", out_valid, 0);
        check("t6_acc", acc_out, 0);
        check("t6_in_ready", in_ready, 1);
        tick();
        out_ready = 1'b1;

        // Random traffic with occasional clr and reset
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            prod_in   = ($urandom_range(0, 1) != 0) ? W'($urandom_range(200, 255)) : W'($urandom_range(0, 255));
            out_ready = ($urandom_range(0, 2) != 0);
            clr       = ($urandom_range(0, 39) == 0);
            rst_n     = ($urandom_range(0, 149) != 0);
            tick();
        end
        in_valid = 1'b0; clr = 1'b0; rst_n = 1'b1; out_ready = 1'b1;
        repeat (2) tick();

        // LEN=1: every accepted product is a result
        for (int i = 0; i < 8; i++) begin
            p = W'($urandom_range(0, 255));
            l1_in_valid = 1'b1;
            l1_prod_in  = p;
            tick();
            l1_in_valid = 1'b0;
            l1_prod_in  = W'($urandom);
            @(negedge clk);
            check("len1_valid", l1_out_valid, 1);
            check("len1_acc", l1_acc_out, p);
            check("len1_ovf", l1_ovf, 0);
            tick();
            @(negedge clk);
            check("len1_released", l1_out_valid, 0);
            check("len1_in_ready", l1_in_ready, 1);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
